// File: rtl/fsk_pkg.sv
// Shared definitions for the framed FSK link: FSM state codes, frame length
// and parity helpers (also used by the framed receiver).
package fsk_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  function automatic int frame_bits(input int data_w, input int parity_en);
    return data_w + ((parity_en != 0) ? 1 : 0) + 2;
  endfunction

  // Zero-extension of narrower words leaves the XOR reduction unchanged.
  function automatic logic parity(input logic [63:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/fsk_tone_gen.sv
// Square-wave tone generator: half-period picked by the current bit value,
// phase-aligned (output high, counter cleared) whenever restart is asserted.
module fsk_tone_gen
  import fsk_pkg::*;
#(
  parameter int HALF_F0 = 8,
  parameter int HALF_F1 = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_restart,
  input  logic i_bit,
  output logic o_fsk
);

  localparam int HALF_MAX = (HALF_F0 > HALF_F1) ? HALF_F0 : HALF_F1;
  localparam int TW = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam logic [TW-1:0] LAST0 = TW'(HALF_F0 - 1);
  localparam logic [TW-1:0] LAST1 = TW'(HALF_F1 - 1);

  logic [TW-1:0] r_cnt;
  logic          r_fsk;
  logic [TW-1:0] w_last;

  assign w_last = i_bit ? LAST1 : LAST0;

  // Enable and restart describe the coming cycle, so the output stays registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_fsk <= 1'b0;
    end else if (!i_enable) begin
      r_cnt <= '0;
      r_fsk <= 1'b0;
    end else if (i_restart) begin
      r_cnt <= '0;
      r_fsk <= 1'b1;
    end else if (r_cnt == w_last) begin
      r_cnt <= '0;
      r_fsk <= ~r_fsk;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_fsk = r_fsk;

endmodule

// File: rtl/fsk_frame_tx.sv
// Framed FSK transmitter: start bit, data LSB first, optional parity, stop bit,
// each bit sent as one of two tones; back-to-back frames without a gap.
module fsk_frame_tx
  import fsk_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int BIT_CYCLES = 160,
  parameter int HALF_F0    = 8,
  parameter int HALF_F1    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              fsk_out,
  output logic              bit_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int FRAME_BITS = frame_bits(DATA_W, PARITY_EN);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  if ((HALF_F0 < 1) || (HALF_F1 < 1)) begin : g_bad_half
    $fatal(1, "fsk_frame_tx: HALF_F0 and HALF_F1 must be at least 1");
  end else if (((BIT_CYCLES % (2 * HALF_F0)) != 0) ||
               ((BIT_CYCLES % (2 * HALF_F1)) != 0)) begin : g_bad_bit_cycles
    $fatal(1, "fsk_frame_tx: BIT_CYCLES must be a multiple of 2*HALF_F0 and 2*HALF_F1");
  end

  logic [0:0]            r_state;
  logic [BW-1:0]         r_bit_cnt;
  logic [CW-1:0]         r_cyc_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_in_ready;
  logic                  r_bit_out;
  logic                  r_busy;
  logic                  r_frame_done;

  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_accept;
  logic [0:0]            w_nxt_state;
  logic [BW-1:0]         w_nxt_bit;
  logic [CW-1:0]         w_nxt_cyc;
  logic [FRAME_BITS-1:0] w_nxt_shift;
  logic                  w_nxt_last;

  assign w_accept = in_valid && r_in_ready;

  // Bit 0 of the frame goes out first; filler above the stop bit is never used.
  always_comb begin
    w_frame = '1;
    w_frame[0] = 1'b0;
    w_frame[DATA_W:1] = in_data;
    if (PARITY_EN != 0) begin
      w_frame[FRAME_BITS-2] = parity(64'(in_data), PARITY_ODD != 0);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_bit   = r_bit_cnt;
    w_nxt_cyc   = r_cyc_cnt;
    w_nxt_shift = r_shift;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nxt_state = SEND;
          w_nxt_bit   = '0;
          w_nxt_cyc   = '0;
          w_nxt_shift = w_frame;
        end
      end
      default: begin
        if (r_cyc_cnt == CYC_LAST) begin
          w_nxt_cyc = '0;
          if (r_bit_cnt == BIT_LAST) begin
            w_nxt_bit = '0;
            if (w_accept) begin
              w_nxt_shift = w_frame;
            end else begin
              w_nxt_state = IDLE;
            end
          end else begin
            w_nxt_bit   = r_bit_cnt + BW'(1);
            w_nxt_shift = {1'b1, r_shift[FRAME_BITS-1:1]};
          end
        end else begin
          w_nxt_cyc = r_cyc_cnt + CW'(1);
        end
      end
    endcase
  end

  assign w_nxt_last = (w_nxt_state == SEND) && (w_nxt_bit == BIT_LAST) &&
                      (w_nxt_cyc == CYC_LAST);

  // Outputs are derived from the next state so they line up with it when registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_cyc_cnt    <= '0;
      r_shift      <= '0;
      r_in_ready   <= 1'b0;
      r_bit_out    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_bit_cnt    <= w_nxt_bit;
      r_cyc_cnt    <= w_nxt_cyc;
      r_shift      <= w_nxt_shift;
      r_in_ready   <= (w_nxt_state == IDLE) || w_nxt_last;
      r_bit_out    <= (w_nxt_state == SEND) ? w_nxt_shift[0] : 1'b1;
      r_busy       <= (w_nxt_state == SEND);
      r_frame_done <= w_nxt_last;
    end
  end

  fsk_tone_gen #(
    .HALF_F0(HALF_F0),
    .HALF_F1(HALF_F1)
  ) u_tone (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_nxt_state == SEND),
    .i_restart(w_nxt_cyc == '0),
    .i_bit    (r_bit_out),
    .o_fsk    (fsk_out)
  );

  assign in_ready   = r_in_ready;
  assign bit_out    = r_bit_out;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fsk_frame_tx.sv
// Bench for fsk_frame_tx: three instances (even parity, odd parity, no parity)
// driven with directed and random words; a negedge monitor scores every cycle.
module tb_fsk_frame_tx;

  localparam int BC = 16;

  typedef struct packed {
    logic [7:0] data;
    int         acc;
  } expT;

  logic       clk;
  logic       reset;
  logic [7:0] dIn [3];
  logic       vIn [3];
  logic [2:0] rdy, fsk, bo, bsy, fd;

  int  cyc = 0;
  int  edgesSinceRst = 0;
  int  assertions = 0;
  int  failures = 0;
  int  fpos [3] = '{-1, -1, -1};
  expT fcur [3];
  expT q0 [$];
  expT q1 [$];
  expT q2 [$];

  logic [4:0] mAct, mExp;
  logic       mBit, mLast;

  fsk_frame_tx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .BIT_CYCLES(BC),
                 .HALF_F0(4), .HALF_F1(2)) u_dut0 (
    .clk(clk), .reset(reset), .in_data(dIn[0]), .in_valid(vIn[0]), .in_ready(rdy[0]),
    .fsk_out(fsk[0]), .bit_out(bo[0]), .busy(bsy[0]), .frame_done(fd[0]));

  fsk_frame_tx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .BIT_CYCLES(BC),
                 .HALF_F0(4), .HALF_F1(2)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(dIn[1]), .in_valid(vIn[1]), .in_ready(rdy[1]),
    .fsk_out(fsk[1]), .bit_out(bo[1]), .busy(bsy[1]), .frame_done(fd[1]));

  fsk_frame_tx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .BIT_CYCLES(BC),
                 .HALF_F0(4), .HALF_F1(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_data(dIn[2]), .in_valid(vIn[2]), .in_ready(rdy[2]),
    .fsk_out(fsk[2]), .bit_out(bo[2]), .busy(bsy[2]), .frame_done(fd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle count and edges seen since reset release
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) edgesSinceRst <= 0;
    else edgesSinceRst <= edgesSinceRst + 1;
  end

  // Reference model: frame layout and tone shape from the link definition
  function automatic int frameLen(input int d);
    return (d == 2) ? 10 : 11;
  endfunction

  function automatic logic modelBit(input int d, input logic [7:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    if (d != 2 && idx == 9) return (^w) ^ (d == 1);
    return 1'b1;
  endfunction

  function automatic logic modelTone(input logic b, input int k);
    int half;
    half = b ? 2 : 4;
    return ((k / half) % 2) == 0;
  endfunction

  function automatic int qSize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int qHeadAcc(input int d);
    case (d)
      0: return q0[0].acc;
      1: return q1[0].acc;
      default: return q2[0].acc;
    endcase
  endfunction

  function automatic expT qPop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qPush(input int d, input expT e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic void qClear(input int d);
    case (d)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic checkOutput(input string name, input int d, input int pos,
                             input logic [4:0] act, input logic [4:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut=%0d pos=%0d busy,bit,fsk,done,ready got=%b expected=%b",
               name, d, pos, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    assertions++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops the expected frame when its acceptance edge has passed
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      mAct = {bsy[d], bo[d], fsk[d], fd[d], rdy[d]};
      if (reset) begin
        fpos[d] = -1;
        qClear(d);
        checkOutput("reset", d, -1, mAct, 5'b00000);
      end else if (edgesSinceRst == 0) begin
        checkOutput("release", d, -1, mAct, 5'b00000);
      end else begin
        if (fpos[d] < 0 && qSize(d) > 0) begin
          if (qHeadAcc(d) == cyc) begin
            fcur[d] = qPop(d);
            fpos[d] = 0;
          end
        end
        if (fpos[d] >= 0) begin
          mBit  = modelBit(d, fcur[d].data, fpos[d] / BC);
          mLast = (fpos[d] == frameLen(d) * BC - 1);
          mExp  = {1'b1, mBit, modelTone(mBit, fpos[d] % BC), mLast, mLast};
          checkOutput("frame", d, fpos[d], mAct, mExp);
          fpos[d]++;
          if (fpos[d] == frameLen(d) * BC) fpos[d] = -1;
        end else begin
          checkOutput("idle", d, -1, mAct, 5'b01001);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge just after the acceptance edge
  task automatic applyStimulus(input int d, input logic [7:0] w, input bit hold,
                               output int acc);
    int waited;
    expT e;
    waited = 0;
    acc = -1;
    dIn[d] = w;
    vIn[d] = 1'b1;
    while (acc < 0 && waited < 2000) begin
      if (rdy[d]) begin
        acc = cyc + 1;
        e.data = w;
        e.acc = acc;
        qPush(d, e);
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    if (acc < 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL accept dut=%0d word=%h not accepted within %0d cycles", d, w, waited);
      vIn[d] = 1'b0;
    end else begin
      @(negedge clk);
      if (!hold) vIn[d] = 1'b0;
    end
  endtask

  task automatic waitAllIdle();
    int n;
    n = 0;
    while ((fpos[0] >= 0 || fpos[1] >= 0 || fpos[2] >= 0 ||
            qSize(0) + qSize(1) + qSize(2) > 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    assertions++;
    if (n >= 3000) begin
      failures++;
      $display("[TB] FAIL drain frames still pending after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a1, a2, d;
    logic [7:0] w;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dIn[i] = 8'h00;
      vIn[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkValue("ready after reset", int'(rdy[0]), 1);
    checkValue("bit_out after reset", int'(bo[0]), 1);

    $display("[TB] 0xA5 even parity");
    applyStimulus(0, 8'hA5, 1'b0, a1);
    waitAllIdle();

    $display("[TB] 0x00 then 0xFF back to back");
    applyStimulus(0, 8'h00, 1'b1, a1);
    applyStimulus(0, 8'hFF, 1'b0, a2);
    checkValue("back-to-back accept edge", a2, a1 + 176);
    waitAllIdle();

    $display("[TB] 0x03 odd parity and no parity");
    applyStimulus(1, 8'h03, 1'b0, a1);
    applyStimulus(2, 8'h03, 1'b0, a2);
    checkValue("no-parity accept edge", a2, a1 + 1);
    waitAllIdle();

    $display("[TB] word presented mid-frame");
    applyStimulus(0, 8'h3C, 1'b0, a1);
    repeat (39) @(negedge clk);
    applyStimulus(0, 8'h96, 1'b0, a2);
    checkValue("mid-frame accept edge", a2, a1 + 176);
    waitAllIdle();

    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'h77, 1'b0, a1);
    repeat (49) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("async reset", i, -1, {bsy[i], bo[i], fsk[i], fd[i], rdy[i]}, 5'b00000);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    applyStimulus(0, 8'h5A, 1'b0, a1);
    waitAllIdle();

    $display("[TB] random words");
    for (int i = 0; i < 9; i++) begin
      d = int'($urandom_range(0, 2));
      w = 8'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      applyStimulus(d, w, 1'b0, a1);
    end
    waitAllIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
